io_hub_irq: RTL
===============

# io_hub_irq

Parametrised memory/IO hub for the single-cycle MIPS core. It splits the data bus between data memory and a bank of `N_OUT` output and `N_IN` input PIO channels. Output channels support atomic set/clear. Input channels add two-flop synchronisation, configurable edge capture into sticky write-1-to-clear flags, per-bit interrupt masking and a single level `irq` to the core.

## Interface
Parameters:
- `N_OUT`, 4: number of output channels, 1..15.
- `N_IN`, 4: number of input channels, 1..15; `N_OUT+N_IN` ≤ 16.
- `WIDTH`, 16: bits per channel, 1..32; register bits above `WIDTH` read 0 and ignore writes.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `addr`  in  32: CPU data address.
- `datain`  in  32: CPU store data.
- `we`  in  1: CPU store strobe.
- `memout`  in  32: data memory read data.
- `dataout`  out  32: load data to the CPU (combinational).
- `wmem`  out  1: data memory write enable.
- `pio_out`  out  `N_OUT*WIDTH`: output channel c occupies bits `[c*WIDTH +: WIDTH]`.
- `pio_in`  in  `N_IN*WIDTH`: input channel i, asynchronous to `clk`.
- `irq`  out  1: OR over all input channels of `EDGE & MASK`.

## Operation
- IO select: `addr[31:28] == 4'hf`. Otherwise the access targets memory: `wmem = we & ~io`, `dataout = memout`.
- Channel index `ch = addr[27:24]`. Index `0..N_OUT-1` selects an output channel. Index `N_OUT..N_OUT+N_IN-1` selects input channel `ch-N_OUT`. Any other index reads 0 and ignores writes.
- Register select `reg = addr[3:2]`. Other address bits are ignored.
- Output channel registers:
  - 0 DATA (rw).
  - 1 SET (w: `DATA |= datain`; reads DATA).
  - 2 CLR (w: `DATA &= ~datain`; reads DATA).
  - 3 reserved (reads 0).
  - `pio_out` is driven directly by DATA.
- Input channel registers:
  - 0 DATA (ro): synchronised input.
  - 1 EDGE (r; write 1 clears the bit).
  - 2 MASK (rw).
  - 3 CFG (rw): bit0 = rising-edge capture, bit1 = falling-edge capture, both set = any edge; only these 2 bits are stored.
- Input pipeline per bit: `s1 <= pio_in`, `s2 <= s1`, `prev <= s2`. DATA reads `s2`.
- Edge detect: `det = (CFG[0] & s2 & ~prev) | (CFG[1] & ~s2 & prev)`. Update: `EDGE <= (EDGE & ~clr) | det`.
- Set wins when detect and W1C hit the same bit in the same cycle.
- Writes take effect at the rising edge where `we & io` is high and the index is valid.
- Reset values: all output DATA, EDGE, MASK, CFG, s1, s2 and prev are 0, so `pio_out = 0` and `irq = 0`. Reset during operation clears everything immediately, with no clock needed.

## Timing
- Reads: `dataout` is combinational from `addr` and state, with zero-cycle latency, as required by the single-cycle core.
- Write to DATA, SET or CLR: new value on `pio_out` right after the write edge.
- Input change held stable before edge E1:
  - `s1` updates at E1.
  - DATA reads the new value after E2.
  - `det` is high during the cycle after E2.
  - The EDGE bit is set at E3.
  - `irq` rises after E3, when MASK is set.
- `irq` is combinational from the EDGE and MASK flops, so it is glitch-free relative to `clk`.
- Pulses shorter than one `clk` period may be missed; this is not an error.
- Writing MASK=0 drops `irq` right after the write edge; EDGE is retained.

## Structure
- Package `io_hub_pkg`: IO tag `4'hf`, register offsets (`REG_DATA`, `REG_SET`, `REG_CLR`, `REG_EDGE`, `REG_MASK`, `REG_CFG`), CFG bit positions.
- Sub-module `io_in_channel` (parameter `WIDTH`), instantiated `N_IN` times by generate. It contains the synchroniser, edge detect, EDGE, MASK and CFG registers, a read mux and a per-channel irq.
- Output channels are inline generate logic in the top level.

## Test plan
- Reset: hold `resetn=0` mid-run with outputs previously written → `pio_out=0`, `irq=0`, and all reads return 0 after release.
- Memory pass-through: `addr=0x00000010`, `we=1` → `wmem=1` and `dataout=memout`. With `addr=0xf0000000`, `we=1` → `wmem=0`.
- Output SET/CLR on ch0: DATA=0x00F0, SET 0x0003, CLR 0x0010 → `pio_out[15:0]=0x00E3`. Write to ch `N_OUT+N_IN` → no state change, and the read returns 0.
- Rising capture on input ch0 (`addr=0xf4000000` with default `N_OUT=4`): CFG=1, MASK=0x0001, `pio_in` bit0 goes 0→1 → EDGE=0x0001 and `irq=1` exactly after the 3rd edge. A W1C of 0x0001 → `irq=0`.
- Falling/any mode: CFG=2 and bit5 toggles 0→1→0 → EDGE=0x0020 only after the fall. With CFG=3, both transitions set it.
- Simultaneous set/clear: W1C on bit0 in the same cycle that `det` is high → EDGE bit0 remains 1.

Source files
------------

// File: rtl/io_hub_irq_pkg.sv
// Address decode constants shared by the IO hub and its input channels.
// Latency: n/a (constants only).
// Backpressure: n/a.
package io_hub_pkg;

  localparam logic [3:0] IO_TAG   = 4'hf;

  // output channel register offsets (addr[3:2])
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_SET  = 2'd1;
  localparam logic [1:0] REG_CLR  = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  // input channel register offsets (addr[3:2]); DATA shares offset 0
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_CFG  = 2'd3;

  // CFG bit positions
  localparam int CFG_RISE = 0;
  localparam int CFG_FALL = 1;

endpackage

// File: rtl/io_hub_irq_in_channel.sv
// Input PIO channel: 2-flop sync, edge capture into sticky W1C flags, mask, irq.
// Latency: input change visible on DATA after 2 edges, EDGE/irq after 3; reads combinational.
// Backpressure: none; writes always accepted, a pulse shorter than a clock may be missed.
module io_in_channel
  import io_hub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pin,
  input  logic             wr,
  input  logic [1:0]       rsel,
  input  logic [31:0]      wdat,
  output logic [31:0]      rdat,
  output logic             irq
);

  logic [WIDTH-1:0] s1, s2, prev;
  logic [WIDTH-1:0] edge_q, mask_q;
  logic [1:0]       cfg_q;
  logic [WIDTH-1:0] det, clr;
  logic             unused_wdat;

  assign unused_wdat = ^wdat;

  // transition detect on the synchronised value, qualified by the capture mode
  assign det = ({WIDTH{cfg_q[CFG_RISE]}} &  s2 & ~prev)
             | ({WIDTH{cfg_q[CFG_FALL]}} & ~s2 &  prev);

  assign clr = (wr && rsel == REG_EDGE) ? wdat[WIDTH-1:0] : '0;

  // synchroniser, sticky edge flags (detect beats clear) and config registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1     <= '0;
      s2     <= '0;
      prev   <= '0;
      edge_q <= '0;
      mask_q <= '0;
      cfg_q  <= '0;
    end else begin
      s1     <= pin;
      s2     <= s1;
      prev   <= s2;
      edge_q <= (edge_q & ~clr) | det;
      if (wr && rsel == REG_MASK) mask_q <= wdat[WIDTH-1:0];
      if (wr && rsel == REG_CFG)  cfg_q  <= wdat[1:0];
    end
  end

  // register read mux, zero-extended to the bus width
  always_comb begin
    rdat = '0;
    case (rsel)
      REG_DATA: rdat = 32'(s2);
      REG_EDGE: rdat = 32'(edge_q);
      REG_MASK: rdat = 32'(mask_q);
      default:  rdat = 32'(cfg_q);
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: rtl/io_hub_irq.sv
// Data bus splitter: data memory vs. output PIO (atomic set/clr) and input PIO with irq.
// Latency: reads combinational (zero cycle); writes land at the strobe edge.
// Backpressure: none; the single-cycle core never stalls, every access completes.
module io_hub_irq
  import io_hub_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int N_IN  = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            addr,
  input  logic [31:0]            datain,
  input  logic                   we,
  input  logic [31:0]            memout,
  output logic [31:0]            dataout,
  output logic                   wmem,
  output logic [N_OUT*WIDTH-1:0] pio_out,
  input  logic [N_IN*WIDTH-1:0]  pio_in,
  output logic                   irq
);

  logic                 io;
  logic [3:0]           ch;
  logic [1:0]           rsel;
  logic                 io_wr;
  logic [31:0]          io_rdat;
  logic [N_IN-1:0][31:0] in_rdat;
  logic [N_IN-1:0]      in_irq;
  logic                 unused_addr;

  assign io          = (addr[31:28] == IO_TAG);
  assign ch          = addr[27:24];
  assign rsel        = addr[3:2];
  assign io_wr       = we & io;
  assign wmem        = we & ~io;
  assign unused_addr = ^{addr[23:4], addr[1:0]};

  genvar c, i;

  for (c = 0; c < N_OUT; c++) begin : g_out
    logic [WIDTH-1:0] q;
    logic             wr;
    assign wr = io_wr && (ch == 4'(c));

    // output DATA register with atomic set/clear aliases
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        q <= '0;
      end else if (wr) begin
        case (rsel)
          REG_DATA: q <= datain[WIDTH-1:0];
          REG_SET:  q <= q |  datain[WIDTH-1:0];
          REG_CLR:  q <= q & ~datain[WIDTH-1:0];
          default:  q <= q;
        endcase
      end
    end

    assign pio_out[c*WIDTH +: WIDTH] = q;
  end

  for (i = 0; i < N_IN; i++) begin : g_in
    io_in_channel #(.WIDTH(WIDTH)) u_in (
      .clk    (clk),
      .resetn (resetn),
      .pin    (pio_in[i*WIDTH +: WIDTH]),
      .wr     (io_wr && (ch == 4'(N_OUT + i))),
      .rsel   (rsel),
      .wdat   (datain),
      .rdat   (in_rdat[i]),
      .irq    (in_irq[i])
    );
  end

  // IO read mux by channel index; unmapped indices read 0
  always_comb begin
    io_rdat = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (ch == 4'(k) && rsel != REG_RSVD) io_rdat = 32'(pio_out[k*WIDTH +: WIDTH]);
    end
    for (int k = 0; k < N_IN; k++) begin
      if (ch == 4'(N_OUT + k)) io_rdat = in_rdat[k];
    end
  end

  assign dataout = io ? io_rdat : memout;
  assign irq     = |in_irq;

endmodule
